// File: rtl/a2d_pkg.sv
// a2d_pkg: slot and state types plus default ADC channel assignments for the A2D round-robin sequencer.
package a2d_pkg;
    typedef enum logic [1:0] {LFT, RGHT, STEER, BATT} slot_t;
    typedef enum logic [1:0] {IDLE, CNV, GAP, RD} seq_state_t;
    localparam logic [2:0] DEF_CH_LFT   = 3'd0;
    localparam logic [2:0] DEF_CH_RGHT  = 3'd4;
    localparam logic [2:0] DEF_CH_STEER = 3'd5;
    localparam logic [2:0] DEF_CH_BATT  = 3'd6;
    localparam int         DEF_GAP_CLKS = 4;
endpackage

// File: rtl/a2d_rr_sequencer.sv
// a2d_rr_sequencer: round-robin two-transaction ADC128S conversions over four slots via spi_mnrch.
module a2d_rr_sequencer
    import a2d_pkg::*;
#(
    parameter logic [2:0] CH_LFT   = DEF_CH_LFT,
    parameter logic [2:0] CH_RGHT  = DEF_CH_RGHT,
    parameter logic [2:0] CH_STEER = DEF_CH_STEER,
    parameter logic [2:0] CH_BATT  = DEF_CH_BATT,
    parameter int         GAP_CLKS = DEF_GAP_CLKS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        nxt,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic        wrt,
    output logic [15:0] wt_data,
    output logic        busy,
    output logic        vld,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] steer_pot,
    output logic [11:0] batt
);
    localparam int GW = $clog2(GAP_CLKS + 1);
    seq_state_t     r_state;
    slot_t          r_slot;
    logic [GW-1:0]  r_gap;
    logic [2:0]     w_ch;
    logic           w_unused;
    assign w_unused = ^rd_data[15:12];
    always_comb w_ch = r_slot == LFT   ? CH_LFT   :
                       r_slot == RGHT  ? CH_RGHT  :
                       r_slot == STEER ? CH_STEER : CH_BATT;
    assign wt_data = {2'b00, w_ch, 11'h000};
    // Gap counter loads GAP_CLKS-1 so wrt rises GAP_CLKS edges after done is sampled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_slot    <= LFT;
            r_gap     <= '0;
            wrt       <= 1'b0;
            busy      <= 1'b0;
            vld       <= 1'b0;
            lft_ld    <= '0;
            rght_ld   <= '0;
            steer_pot <= '0;
            batt      <= '0;
        end else begin
            wrt <= 1'b0;
            vld <= 1'b0;
            case (r_state)
                IDLE: if (nxt) begin
                    wrt     <= 1'b1;
                    busy    <= 1'b1;
                    r_state <= CNV;
                end
                CNV: if (done) begin
                    r_gap   <= GW'(GAP_CLKS - 1);
                    r_state <= GAP;
                end
                GAP: if (r_gap == '0) begin
                    wrt     <= 1'b1;
                    r_state <= RD;
                end else r_gap <= r_gap - 1'b1;
                RD: if (done) begin
                    case (r_slot)
                        LFT:     lft_ld    <= rd_data[11:0];
                        RGHT:    rght_ld   <= rd_data[11:0];
                        STEER:   steer_pot <= rd_data[11:0];
                        default: batt      <= rd_data[11:0];
                    endcase
                    vld     <= 1'b1;
                    busy    <= 1'b0;
                    r_slot  <= slot_t'(r_slot + 2'd1);
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule
